// File: rtl/memory_address_sequencer_pkg.sv
// Shared definitions for the memory address sequencer and its helpers.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: FSM state encoding, access-size encoding, default geometry.
package memory_address_sequencer_pkg;

    // Burst sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_GAP    = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Access size, used only for the base-address alignment check
    typedef enum logic [1:0] {
        SZ_BYTE   = 2'd0,
        SZ_HALF   = 2'd1,
        SZ_WORD   = 2'd2,
        SZ_DOUBLE = 2'd3
    } size_e;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_WORD_BYTES = 4;
    localparam int DEF_MAX_BURST  = 4;

endpackage

// File: rtl/memory_address_sequencer_if.sv
// Control-unit/memory-side bundle of the memory address sequencer.
// Latency: n/a (wires only).
// Backpressure: MFA/MOC request/complete handshake toward memory.
// master = control unit / memory model side, slave = sequencer side.
interface memory_address_sequencer_if
    import memory_address_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BURST_W    = $clog2(DEF_MAX_BURST + 1)
);
    // Requests into the sequencer
    logic [ADDR_WIDTH-1:0] Memory_Address;
    logic                  MAR_Ld;
    logic                  Start;
    logic [BURST_W-1:0]    Burst_Len;
    logic [1:0]            Size;
    logic                  MOC;
    // Registered sequencer outputs
    logic [ADDR_WIDTH-1:0] MA;
    logic                  MFA;
    logic                  Busy;
    logic                  Done;
    logic                  Align_Err;
    logic [BURST_W-1:0]    Beat;

    modport master (
        output Memory_Address, MAR_Ld, Start, Burst_Len, Size, MOC,
        input  MA, MFA, Busy, Done, Align_Err, Beat
    );

    modport slave (
        input  Memory_Address, MAR_Ld, Start, Burst_Len, Size, MOC,
        output MA, MFA, Busy, Done, Align_Err, Beat
    );

endinterface

// File: rtl/mem_align_check.sv
// Purpose: flags an address that is not naturally aligned for the access size.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: addr_i (address), size_i (0 byte .. 3 double), misaligned_o.
module mem_align_check
    import memory_address_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [1:0]            size_i,
    output logic                  misaligned_o
);

    logic [ADDR_WIDTH-1:0] low_mask;

    // low_mask = (1 << size) - 1, spelled out per size
    always_comb begin
        low_mask = '0;
        case (size_e'(size_i))
            SZ_BYTE:   low_mask = '0;
            SZ_HALF:   low_mask = ADDR_WIDTH'(1);
            SZ_WORD:   low_mask = ADDR_WIDTH'(3);
            SZ_DOUBLE: low_mask = ADDR_WIDTH'(7);
            default:   low_mask = '0;
        endcase
        misaligned_o = |(addr_i & low_mask);
    end

endmodule

// File: rtl/memory_address_sequencer.sv
// Purpose: memory address register with legacy single load plus an N-beat burst sequencer.
// Latency: load/start take effect on the next falling Clock edge; each beat waits on MOC.
// Backpressure: MFA held until MOC=1; next beat waits for MOC=0 (at least one MFA-low cycle).
// Ports: Clock, Reset (sync, active-low, falling edge), bus (slave modport) carrying
//        Memory_Address/MAR_Ld/Start/Burst_Len/Size/MOC in and MA/MFA/Busy/Done/Align_Err/Beat out.
module memory_address_sequencer
    import memory_address_sequencer_pkg::*;
#(
    parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter  int WORD_BYTES = DEF_WORD_BYTES,
    parameter  int MAX_BURST  = DEF_MAX_BURST,
    localparam int BURST_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                       Clock,
    input  logic                       Reset,
    memory_address_sequencer_if.slave  bus
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ma_q, ma_d;
    logic                  mfa_q, mfa_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  align_err_q, align_err_d;
    logic [BURST_W-1:0]    beat_q, beat_d;
    logic [BURST_W-1:0]    rem_q, rem_d;   // beats still to issue, including current

    logic                  misaligned;
    logic [BURST_W-1:0]    eff_len;

    mem_align_check #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_align (
        .addr_i       (bus.Memory_Address),
        .size_i       (bus.Size),
        .misaligned_o (misaligned)
    );

    // Zero-length requests still move one word; oversize requests are clamped.
    always_comb begin
        if (bus.Burst_Len == '0) begin
            eff_len = BURST_W'(1);
        end else if (bus.Burst_Len > BURST_W'(MAX_BURST)) begin
            eff_len = BURST_W'(MAX_BURST);
        end else begin
            eff_len = bus.Burst_Len;
        end
    end

    always_comb begin
        state_d     = state_q;
        ma_d        = ma_q;
        mfa_d       = mfa_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        align_err_d = align_err_q;
        beat_d      = beat_q;
        rem_d       = rem_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    // Faulting address is kept in MA for the trap handler.
                    ma_d = bus.Memory_Address;
                    if (misaligned) begin
                        align_err_d = 1'b1;
                    end else begin
                        align_err_d = 1'b0;
                        beat_d      = '0;
                        rem_d       = eff_len;
                        mfa_d       = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = ST_ACCESS;
                    end
                end else if (bus.MAR_Ld) begin
                    ma_d        = bus.Memory_Address;
                    align_err_d = 1'b0;
                end
            end

            ST_ACCESS: begin
                if (bus.MOC) begin
                    mfa_d = 1'b0;
                    if (rem_q == BURST_W'(1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        // Wraps silently at the top of the address space.
                        ma_d    = ma_q + ADDR_WIDTH'(WORD_BYTES);
                        beat_d  = beat_q + BURST_W'(1);
                        rem_d   = rem_q - BURST_W'(1);
                        state_d = ST_GAP;
                    end
                end
            end

            ST_GAP: begin
                // Memory must drop MOC before the next request is raised.
                if (!bus.MOC) begin
                    mfa_d   = 1'b1;
                    state_d = ST_ACCESS;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(negedge Clock) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            ma_q        <= '0;
            mfa_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            align_err_q <= 1'b0;
            beat_q      <= '0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            ma_q        <= ma_d;
            mfa_q       <= mfa_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            align_err_q <= align_err_d;
            beat_q      <= beat_d;
            rem_q       <= rem_d;
        end
    end

    assign bus.MA        = ma_q;
    assign bus.MFA       = mfa_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Align_Err = align_err_q;
    assign bus.Beat      = beat_q;

endmodule
